// File: rtl/sram_2rw_param_if.sv
// sram_2rw_param_if: two-port SRAM request/response bundle plus init_done and collision status
interface sram_2rw_param_if #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 128,
    parameter int MASK_GRAN = 8
);
    localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LANES  = WIDTH / MASK_GRAN;
    logic              init_done, collision;
    logic [ADDR_W-1:0] A1, A2;
    logic              CSB1, WEB1, OEB1, CSB2, WEB2, OEB2;
    logic [LANES-1:0]  M1, M2;
    logic [WIDTH-1:0]  I1, I2, O1, O2;
    modport master (
        output A1, CSB1, WEB1, OEB1, M1, I1, A2, CSB2, WEB2, OEB2, M2, I2,
        input  O1, O2, init_done, collision
    );
    modport slave (
        input  A1, CSB1, WEB1, OEB1, M1, I1, A2, CSB2, WEB2, OEB2, M2, I2,
        output O1, O2, init_done, collision
    );
endinterface

// File: rtl/sram_2rw_param.sv
// sram_2rw_param: parametrised two-port masked-write SRAM with clear sweep, collision policy and 1/2-cycle reads
module sram_2rw_param #(
    parameter int              WIDTH          = 16,
    parameter int              DEPTH          = 128,
    parameter int              MASK_GRAN      = 8,
    parameter int              READ_LATENCY   = 1,
    parameter bit              READ_FIRST     = 1,
    parameter bit              CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0
) (
    input logic              clock,
    input logic              reset,
    sram_2rw_param_if.slave  bus
);
    localparam int ADDR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LANES  = WIDTH / MASK_GRAN;

    typedef enum logic [1:0] {IDLE_RST, CLEAR, READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic              ready, clr, last, re1, re2, we1, we2;
    logic [WIDTH-1:0]  d1, d2, p1_q, p2_q, o1_q, o2_q;
    logic              v1_q, v2_q, collision_q;

    assign ready = state_q == READY && !reset;
    assign clr   = state_q == CLEAR && !reset;
    assign last  = int'(cnt_q) == DEPTH - 1;
    assign re1   = ready && !bus.CSB1 && !bus.OEB1;
    assign re2   = ready && !bus.CSB2 && !bus.OEB2;
    assign we1   = ready && !bus.CSB1 && !bus.WEB1;
    assign we2   = ready && !bus.CSB2 && !bus.WEB2;

    function automatic logic [WIDTH-1:0] peek(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH ? mem[a] : '0;
    endfunction

    // Port 2 lanes applied first so port 1 wins on lanes both ports enable
    function automatic logic [WIDTH-1:0] merged(input logic [ADDR_W-1:0] a);
        logic [WIDTH-1:0] w;
        w = peek(a);
        for (int k = 0; k < LANES; k++) begin
            if (we2 && bus.A2 == a && bus.M2[k]) w[k*MASK_GRAN +: MASK_GRAN] = bus.I2[k*MASK_GRAN +: MASK_GRAN];
            if (we1 && bus.A1 == a && bus.M1[k]) w[k*MASK_GRAN +: MASK_GRAN] = bus.I1[k*MASK_GRAN +: MASK_GRAN];
        end
        return int'(a) < DEPTH ? w : '0;
    endfunction

    assign d1 = READ_FIRST ? peek(bus.A1) : merged(bus.A1);
    assign d2 = READ_FIRST ? peek(bus.A2) : merged(bus.A2);

    always_comb begin
        state_d = state_q == IDLE_RST ? (CLEAR_ON_RESET ? CLEAR : READY)
                : (state_q == CLEAR && last) ? READY : state_q;
        cnt_d   = (state_q == CLEAR && !last) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clock) begin
        if (clr) mem[cnt_q] <= INIT_VALUE;
        if (we1 && int'(bus.A1) < DEPTH) mem[bus.A1] <= merged(bus.A1);
        if (we2 && int'(bus.A2) < DEPTH) mem[bus.A2] <= merged(bus.A2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE_RST;
            cnt_q       <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            o1_q        <= '0;
            o2_q        <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            v1_q        <= re1;
            v2_q        <= re2;
            if (re1) p1_q <= d1;
            if (re2) p2_q <= d2;
            if (READ_LATENCY == 1 ? re1 : v1_q) o1_q <= READ_LATENCY == 1 ? d1 : p1_q;
            if (READ_LATENCY == 1 ? re2 : v2_q) o2_q <= READ_LATENCY == 1 ? d2 : p2_q;
            collision_q <= we1 && we2 && bus.A1 == bus.A2 && |(bus.M1 & bus.M2);
        end
    end

    assign bus.O1        = o1_q;
    assign bus.O2        = o2_q;
    assign bus.init_done = state_q == READY;
    assign bus.collision = collision_q;
endmodule

// File: tb/tb_sram_2rw_param.sv
// tb_sram_2rw_param: scoreboard bench for a 128-word read-first/latency-1 SRAM and a 100-word write-first/latency-2 SRAM
module tb_sram_2rw_param;
    logic        clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
    int          n_cmp = 0, n_err = 0;
    logic [15:0] sb1[$], sb2[$];
    logic [15:0] e;

    always #5 clk = ~clk;

    sram_2rw_param_if #(.WIDTH(16), .DEPTH(128), .MASK_GRAN(8)) bus_a ();
    sram_2rw_param_if #(.WIDTH(16), .DEPTH(100), .MASK_GRAN(8)) bus_b ();

    sram_2rw_param #(.WIDTH(16), .DEPTH(128), .MASK_GRAN(8), .READ_LATENCY(1), .READ_FIRST(1),
                     .CLEAR_ON_RESET(1), .INIT_VALUE(16'hA5A5))
        dut_a (.clock(clk), .reset(rst_a), .bus(bus_a));
    sram_2rw_param #(.WIDTH(16), .DEPTH(100), .MASK_GRAN(8), .READ_LATENCY(2), .READ_FIRST(0),
                     .CLEAR_ON_RESET(1), .INIT_VALUE(16'h0000))
        dut_b (.clock(clk), .reset(rst_b), .bus(bus_b));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus_a.CSB1 = 1; bus_a.WEB1 = 1; bus_a.OEB1 = 1; bus_a.A1 = '0; bus_a.M1 = '0; bus_a.I1 = '0;
        bus_a.CSB2 = 1; bus_a.WEB2 = 1; bus_a.OEB2 = 1; bus_a.A2 = '0; bus_a.M2 = '0; bus_a.I2 = '0;
        bus_b.CSB1 = 1; bus_b.WEB1 = 1; bus_b.OEB1 = 1; bus_b.A1 = '0; bus_b.M1 = '0; bus_b.I1 = '0;
        bus_b.CSB2 = 1; bus_b.WEB2 = 1; bus_b.OEB2 = 1; bus_b.A2 = '0; bus_b.M2 = '0; bus_b.I2 = '0;
    endtask

    task automatic test_reset;
        idle();
        rst_a = 1; rst_b = 1;
        repeat (3) tick();
        n_cmp++; if (bus_a.O1 !== 16'h0) begin n_err++; $display("FAIL reset_O1 got=%h exp=0000", bus_a.O1); end
        n_cmp++; if (bus_a.O2 !== 16'h0) begin n_err++; $display("FAIL reset_O2 got=%h exp=0000", bus_a.O2); end
        n_cmp++; if (bus_a.init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done got=%b exp=0", bus_a.init_done); end
        n_cmp++; if (bus_a.collision !== 1'b0) begin n_err++; $display("FAIL reset_collision got=%b exp=0", bus_a.collision); end
        n_cmp++; if (bus_b.init_done !== 1'b0) begin n_err++; $display("FAIL reset_b_init_done got=%b exp=0", bus_b.init_done); end
    endtask

    task automatic test_clear_sweep;
        int n = 0;
        rst_a = 0;
        tick();
        while (bus_a.init_done !== 1'b1 && n < 1000) begin
            idle();
            if (n == 10) begin bus_a.CSB1 = 0; bus_a.WEB1 = 0; bus_a.A1 = 7'h00; bus_a.I1 = 16'h1234; bus_a.M1 = 2'b11; end
            tick();
            n++;
        end
        idle();
        n_cmp++; if (n != 128) begin n_err++; $display("FAIL sweep_cycles got=%0d exp=128", n); end
        bus_a.CSB1 = 0; bus_a.OEB1 = 0; bus_a.A1 = 7'h7F; sb1.push_back(16'hA5A5);
        bus_a.CSB2 = 0; bus_a.OEB2 = 0; bus_a.A2 = 7'h00; sb2.push_back(16'hA5A5);
        tick();
        idle();
        e = sb1.pop_front();
        n_cmp++; if (bus_a.O1 !== e) begin n_err++; $display("FAIL sweep_read_7F got=%h exp=%h", bus_a.O1, e); end
        e = sb2.pop_front();
        n_cmp++; if (bus_a.O2 !== e) begin n_err++; $display("FAIL write_during_clear got=%h exp=%h", bus_a.O2, e); end
    endtask

    task automatic test_masked_write;
        idle(); bus_a.CSB1 = 0; bus_a.WEB1 = 0; bus_a.A1 = 7'h10; bus_a.I1 = 16'h1234; bus_a.M1 = 2'b11; tick();
        bus_a.I1 = 16'hFFEE; bus_a.M1 = 2'b01; tick();
        bus_a.I1 = 16'h0000; bus_a.M1 = 2'b00; tick();
        idle(); bus_a.CSB1 = 0; bus_a.OEB1 = 0; bus_a.A1 = 7'h10; sb1.push_back(16'h12EE); tick();
        idle();
        e = sb1.pop_front();
        n_cmp++; if (bus_a.O1 !== e) begin n_err++; $display("FAIL masked_write got=%h exp=%h", bus_a.O1, e); end
        tick();
        n_cmp++; if (bus_a.O1 !== e) begin n_err++; $display("FAIL O1_hold got=%h exp=%h", bus_a.O1, e); end
    endtask

    task automatic test_read_during_write;
        idle(); bus_a.CSB1 = 0; bus_a.WEB1 = 0; bus_a.A1 = 7'h20; bus_a.I1 = 16'h0001; bus_a.M1 = 2'b11; tick();
        bus_a.I1 = 16'hBEEF;
        bus_a.CSB2 = 0; bus_a.OEB2 = 0; bus_a.A2 = 7'h20; sb2.push_back(16'h0001); tick();
        idle();
        e = sb2.pop_front();
        n_cmp++; if (bus_a.O2 !== e) begin n_err++; $display("FAIL rdw_read_first got=%h exp=%h", bus_a.O2, e); end
        bus_a.CSB2 = 0; bus_a.OEB2 = 0; bus_a.A2 = 7'h20; sb2.push_back(16'hBEEF); tick();
        idle();
        e = sb2.pop_front();
        n_cmp++; if (bus_a.O2 !== e) begin n_err++; $display("FAIL rdw_after got=%h exp=%h", bus_a.O2, e); end
    endtask

    task automatic test_collision;
        idle();
        bus_a.CSB1 = 0; bus_a.WEB1 = 0; bus_a.A1 = 7'h05; bus_a.I1 = 16'h1111; bus_a.M1 = 2'b11;
        bus_a.CSB2 = 0; bus_a.WEB2 = 0; bus_a.A2 = 7'h05; bus_a.I2 = 16'h2222; bus_a.M2 = 2'b10;
        tick(); idle();
        n_cmp++; if (bus_a.collision !== 1'b1) begin n_err++; $display("FAIL collision_rise got=%b exp=1", bus_a.collision); end
        bus_a.CSB1 = 0; bus_a.OEB1 = 0; bus_a.A1 = 7'h05; sb1.push_back(16'h1111); tick(); idle();
        n_cmp++; if (bus_a.collision !== 1'b0) begin n_err++; $display("FAIL collision_pulse got=%b exp=0", bus_a.collision); end
        e = sb1.pop_front();
        n_cmp++; if (bus_a.O1 !== e) begin n_err++; $display("FAIL collision_p1_wins got=%h exp=%h", bus_a.O1, e); end
        bus_a.CSB1 = 0; bus_a.WEB1 = 0; bus_a.A1 = 7'h05; bus_a.I1 = 16'h1111; bus_a.M1 = 2'b01;
        bus_a.CSB2 = 0; bus_a.WEB2 = 0; bus_a.A2 = 7'h05; bus_a.I2 = 16'h2222; bus_a.M2 = 2'b10;
        tick(); idle();
        n_cmp++; if (bus_a.collision !== 1'b0) begin n_err++; $display("FAIL disjoint_lanes_collision got=%b exp=0", bus_a.collision); end
        bus_a.CSB1 = 0; bus_a.OEB1 = 0; bus_a.A1 = 7'h05; sb1.push_back(16'h2211); tick(); idle();
        e = sb1.pop_front();
        n_cmp++; if (bus_a.O1 !== e) begin n_err++; $display("FAIL disjoint_lanes_merge got=%h exp=%h", bus_a.O1, e); end
        bus_a.CSB1 = 0; bus_a.WEB1 = 0; bus_a.A1 = 7'h06; bus_a.I1 = 16'h0606; bus_a.M1 = 2'b11;
        bus_a.CSB2 = 0; bus_a.WEB2 = 0; bus_a.A2 = 7'h07; bus_a.I2 = 16'h0707; bus_a.M2 = 2'b11;
        tick(); idle();
        n_cmp++; if (bus_a.collision !== 1'b0) begin n_err++; $display("FAIL diff_addr_collision got=%b exp=0", bus_a.collision); end
        bus_a.CSB1 = 0; bus_a.OEB1 = 0; bus_a.A1 = 7'h07; sb1.push_back(16'h0707);
        bus_a.CSB2 = 0; bus_a.OEB2 = 0; bus_a.A2 = 7'h06; sb2.push_back(16'h0606);
        tick(); idle();
        e = sb1.pop_front();
        n_cmp++; if (bus_a.O1 !== e) begin n_err++; $display("FAIL diff_addr_p2 got=%h exp=%h", bus_a.O1, e); end
        e = sb2.pop_front();
        n_cmp++; if (bus_a.O2 !== e) begin n_err++; $display("FAIL diff_addr_p1 got=%h exp=%h", bus_a.O2, e); end
    endtask

    task automatic test_mid_sweep_reset;
        int n = 0;
        idle();
        rst_b = 0; tick();
        repeat (50) tick();
        rst_b = 1; tick();
        n_cmp++; if (bus_b.init_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_init_done got=%b exp=0", bus_b.init_done); end
        rst_b = 0; tick();
        while (bus_b.init_done !== 1'b1 && n < 1000) begin tick(); n++; end
        n_cmp++; if (n != 100) begin n_err++; $display("FAIL mid_reset_sweep_cycles got=%0d exp=100", n); end
    endtask

    task automatic test_write_first_latency2;
        idle();
        bus_b.CSB1 = 0; bus_b.WEB1 = 0; bus_b.A1 = 7'h20; bus_b.I1 = 16'hBEEF; bus_b.M1 = 2'b11;
        bus_b.CSB2 = 0; bus_b.OEB2 = 0; bus_b.A2 = 7'h20; sb2.push_back(16'hBEEF);
        tick(); idle(); tick();
        e = sb2.pop_front();
        n_cmp++; if (bus_b.O2 !== e) begin n_err++; $display("FAIL rdw_write_first got=%h exp=%h", bus_b.O2, e); end
        bus_b.CSB1 = 0; bus_b.WEB1 = 0; bus_b.A1 = 7'h30; bus_b.I1 = 16'h1111; bus_b.M1 = 2'b01;
        bus_b.CSB2 = 0; bus_b.WEB2 = 0; bus_b.OEB2 = 0; bus_b.A2 = 7'h30; bus_b.I2 = 16'h2222; bus_b.M2 = 2'b11;
        sb2.push_back(16'h2211);
        tick(); idle();
        n_cmp++; if (bus_b.collision !== 1'b1) begin n_err++; $display("FAIL b_collision got=%b exp=1", bus_b.collision); end
        tick();
        e = sb2.pop_front();
        n_cmp++; if (bus_b.O2 !== e) begin n_err++; $display("FAIL write_first_merge got=%h exp=%h", bus_b.O2, e); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) begin
            idle(); bus_b.CSB1 = 0; bus_b.WEB1 = 0; bus_b.A1 = 7'(i); bus_b.M1 = 2'b11;
            bus_b.I1 = (i == 4) ? 16'hDEAD : 16'(i);
            tick();
        end
        idle(); bus_b.CSB1 = 0; bus_b.OEB1 = 0; bus_b.A1 = 7'd4; tick(); idle(); tick();
        for (int i = 0; i < 5; i++) begin
            idle();
            if (i < 4) begin bus_b.CSB1 = 0; bus_b.OEB1 = 0; bus_b.A1 = 7'(i); sb1.push_back(16'(i)); end
            tick();
            if (i == 0) begin
                n_cmp++; if (bus_b.O1 !== 16'hDEAD) begin n_err++; $display("FAIL lat2_early got=%h exp=dead", bus_b.O1); end
            end else begin
                e = sb1.pop_front();
                n_cmp++; if (bus_b.O1 !== e) begin n_err++; $display("FAIL lat2_b2b[%0d] got=%h exp=%h", i - 1, bus_b.O1, e); end
            end
        end
        idle();
    endtask

    task automatic test_boundary;
        idle(); bus_b.CSB1 = 0; bus_b.WEB1 = 0; bus_b.A1 = 7'd101; bus_b.I1 = 16'hFFFF; bus_b.M1 = 2'b11; tick();
        for (int i = 0; i < 103; i++) begin
            idle();
            if (i < 102) begin
                bus_b.CSB1 = 0; bus_b.OEB1 = 0; bus_b.A1 = 7'(i);
                sb1.push_back(i < 4 ? 16'(i) : i == 4 ? 16'hDEAD : i == 32 ? 16'hBEEF : i == 48 ? 16'h2211 : 16'h0000);
            end
            tick();
            if (i > 0) begin
                e = sb1.pop_front();
                n_cmp++; if (bus_b.O1 !== e) begin n_err++; $display("FAIL boundary_read[%0d] got=%h exp=%h", i - 1, bus_b.O1, e); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_masked_write();
        test_read_during_write();
        test_collision();
        test_mid_sweep_reset();
        test_write_first_latency2();
        test_back_to_back();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_2rw_param.md
Name: sram_2rw_param

Overview:
Parametrised synchronous two-port read/write SRAM behavioural model, successor to the fixed 128x16 dual-port macro model. Both ports share one clock. New over the fixed model: configurable width, depth and read latency; per-lane write masks; a defined collision policy; a hardware clear-on-reset sequencer. Used as the simulation and synthesis-stub memory behind cache and register-file wrappers.

Parameters:
WIDTH, 16, data bits per word
DEPTH, 128, number of words (need not be a power of two)
MASK_GRAN, 8, bits per write-mask lane; WIDTH must be a multiple of MASK_GRAN
READ_LATENCY, 1, cycles from read request to data on O1/O2; legal values 1 or 2
READ_FIRST, 1, 1 = a read colliding with a same-cycle write returns old data; 0 = returns newly written data
CLEAR_ON_RESET, 1, 1 = memory is swept to INIT_VALUE after reset
INIT_VALUE, 0, word written during the clear sweep

Ports:
clock  in  1  single clock; all state changes on posedge
reset  in  1  synchronous, active-high
init_done  out  1  high once the memory accepts requests
A1  in  ADDR_W  port-1 address; ADDR_W = max(1, clog2(DEPTH))
CSB1  in  1  port-1 chip select, active-low
WEB1  in  1  port-1 write enable, active-low
OEB1  in  1  port-1 read enable, active-low
M1  in  WIDTH/MASK_GRAN  port-1 write lane mask, active-high
I1  in  WIDTH  port-1 write data
O1  out  WIDTH  port-1 read data
A2, CSB2, WEB2, OEB2, M2, I2, O2: same as port 1, for port 2
collision  out  1  one-cycle pulse on a same-address write-write overlap

Behaviour:
- Decode per port: RE = ~CSB & ~OEB; WE = ~CSB & ~WEB. Read and write on the same port in the same cycle is legal.
- Reset (sampled high at posedge): O1 = O2 = 0, collision = 0, init_done = 0, sweep counter = 0. Memory contents are not touched while reset is high.
- Reset reasserted mid-sweep: the sweep restarts from address 0 after reset releases.
- FSM states: IDLE_RST, CLEAR, READY.
  - IDLE_RST: occupied while reset is high.
  - First cycle after release: go to CLEAR if CLEAR_ON_RESET = 1, else go to READY.
  - CLEAR: writes INIT_VALUE to address cnt each cycle, cnt = 0..DEPTH-1, taking exactly DEPTH cycles. Enters READY on the cycle after address DEPTH-1 is written.
  - init_done = (state == READY).
- Requests while not READY: ignored. No memory write occurs; O1/O2 hold their values; collision stays 0.
- Write: for each lane k with M[k] = 1, word[A] bits [k*MASK_GRAN +: MASK_GRAN] take I. Lanes with M[k] = 0 are unchanged. A write with M all-zero is a no-op.
- Read timing:
  - READ_LATENCY = 1: O updates at the posedge that samples RE.
  - READ_LATENCY = 2: the value passes through one extra output register, so O updates one posedge later.
  - O holds its last value when no read is pending.
  - Pipelined reads issue back-to-back at one per cycle per port.
- Out-of-range address (A >= DEPTH): the write is dropped; the read returns 0.
- Read/write overlap: if a port reads address X in the same cycle either port writes X, the read data depends on READ_FIRST.
  - READ_FIRST = 1: returns the pre-write word.
  - READ_FIRST = 0: returns the post-write merged word, including the port-precedence result below.
- Write-write overlap: both ports write the same address in one cycle.
  - Lanes enabled on only one port take that port's data.
  - Lanes enabled on both ports take port-1 data (port 1 has priority).
  - collision = 1 on the next cycle only if at least one lane was enabled on both ports; otherwise collision stays 0.
- Simultaneous writes to different addresses complete independently, with no collision.
- Memory contents are X-free after CLEAR. With CLEAR_ON_RESET = 0, contents are undefined until written.

Test Plan:
- Clear sweep: DEPTH = 128, CLEAR_ON_RESET = 1, INIT_VALUE = 16'hA5A5, reset 3 cycles then release. Required: init_done rises exactly 128 cycles after release; a read of address 0x7F returns 16'hA5A5. A port-1 write issued during CLEAR is ignored.
- Masked write, READ_LATENCY = 1: write 16'h1234 to 0x10 with M1 = 2'b11. Then write 16'hFFEE with M1 = 2'b01. Required: a read of 0x10 returns 16'h12EE one cycle after the read request.
- Read-during-write, READ_FIRST = 1: word 0x20 = 16'h0001. In one cycle, port 1 writes 16'hBEEF to 0x20 and port 2 reads 0x20. Required: O2 = 16'h0001, and the following port-2 read returns 16'hBEEF. With READ_FIRST = 0, O2 = 16'hBEEF on the first read.
- Write-write collision: same cycle, port 1 writes 16'h1111 with M1 = 2'b11 and port 2 writes 16'h2222 with M2 = 2'b10, both to 0x05. Required: collision is a 1-cycle pulse and 0x05 reads 16'h1111. Repeat with M1 = 2'b01, M2 = 2'b10. Required: 0x05 reads 16'h2211 and collision stays 0.
- Latency 2 with back-to-back reads: READ_LATENCY = 2; preload 0..3 with 16'h0000..16'h0003; port-1 reads 0,1,2,3 on consecutive cycles. Required: O1 shows 0,1,2,3 on consecutive cycles, starting 2 cycles after the first request.
- Boundaries: DEPTH = 100, read of address 100 returns 0 and a write to 101 changes nothing. Separately, reset asserted at sweep cycle 50 for 1 cycle: init_done rises DEPTH cycles after the second release.
